adc_src_mux: RTL and testbench



---
 rtl/adc_src_mux_pkg.sv | 33 +++
 rtl/adc_src_mux_src_arbiter.sv | 66 ++++++
 rtl/adc_src_mux.sv | 119 +++++++++++
 tb/tb_adc_src_mux.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_src_mux_pkg.sv
// Shared constants, write-bus register map and defaults for adc_src_mux.
// Arbitration style is selected by SRC_RR_ARB_EN (round-robin) vs fixed priority.
package adc_src_mux_pkg;

  localparam int W_SRC_DEF     = 5;
  localparam int N_SRC_DEF     = 8;
  localparam int W_DATA_DEF    = 18;
  localparam int W_WR_ADDR_DEF = 16;
  localparam int W_WR_CHAN_DEF = 16;
  localparam int W_WR_DATA_DEF = 48;

  localparam int SRC_EN_ADDR  = 'h0010;
  localparam int OVR_CLR_ADDR = 'h0011;

  typedef enum logic [1:0] {
    WR_NOP,
    WR_SRC_EN,
    WR_OVR_CLR
  } wr_op_e;

  // All-ones source index marks "no word"; never assigned to a real source.
  function automatic int null_src(input int w_src);
    return (1 << w_src) - 1;
  endfunction

  function automatic wr_op_e decode_wr(input logic en, input int addr);
    if (!en)                    return WR_NOP;
    else if (addr == SRC_EN_ADDR)  return WR_SRC_EN;
    else if (addr == OVR_CLR_ADDR) return WR_OVR_CLR;
    else                        return WR_NOP;
  endfunction

endpackage

// File: rtl/adc_src_mux_src_arbiter.sv
// Combinational single-grant arbiter over the pending vector.
// SRC_RR_ARB_EN defined: round-robin with a local last-grant pointer; otherwise lowest index wins.
module src_arbiter
  import adc_src_mux_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int W_SRC = W_SRC_DEF
) (
`ifdef SRC_RR_ARB_EN
  input  logic             clk,
  input  logic             srst,
`endif
  input  logic [N_SRC-1:0] pend,
  output logic [N_SRC-1:0] grant,
  output logic [W_SRC-1:0] grant_idx,
  output logic             grant_vld
);

`ifdef SRC_RR_ARB_EN
  localparam int W_IDX = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [W_SRC-1:0] ptr_reg;

  always_comb begin
    int cand;
    logic [W_IDX-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    // Search begins just after the last granted source and wraps once.
    for (int i = 1; i <= N_SRC; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= N_SRC) cand = cand - N_SRC;
      cand_idx = W_IDX'(cand);
      if (!grant_vld && pend[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = W_SRC'(cand);
        grant_vld       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst)           ptr_reg <= W_SRC'(N_SRC - 1);
    else if (grant_vld) ptr_reg <= grant_idx;
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    // Descending scan so the lowest pending index is the one left standing.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = W_SRC'(i);
        grant_vld = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/adc_src_mux.sv
// Serializes per-source ADC samples into one {source, data} word per clock, with enables and sticky overruns.
// Arbitration: SRC_RR_ARB_EN defined selects round-robin, otherwise fixed lowest-index priority.
module adc_src_mux
  import adc_src_mux_pkg::*;
#(
  parameter int W_SRC     = W_SRC_DEF,
  parameter int N_SRC     = N_SRC_DEF,
  parameter int W_DATA    = W_DATA_DEF,
  parameter int W_WR_ADDR = W_WR_ADDR_DEF,
  parameter int W_WR_CHAN = W_WR_CHAN_DEF,
  parameter int W_WR_DATA = W_WR_DATA_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [N_SRC-1:0]        adc_dv_in,
  input  logic [N_SRC*W_DATA-1:0] adc_data_in,
  input  logic                    wr_en,
  input  logic [W_WR_ADDR-1:0]    wr_addr,
  input  logic [W_WR_CHAN-1:0]    wr_chan,
  input  logic [W_WR_DATA-1:0]    wr_data,
  output logic                    dv_out,
  output logic [W_SRC-1:0]        src_out,
  output logic [W_DATA-1:0]       data_out,
  output logic [N_SRC-1:0]        ovr_out
);

  localparam logic [W_SRC-1:0] NULL_SRC = W_SRC'(null_src(W_SRC));

  logic [N_SRC-1:0]             src_en_reg, src_en_next;
  logic [N_SRC-1:0]             pend_reg, pend_next;
  logic [N_SRC-1:0]             ovr_reg, ovr_next;
  logic [N_SRC-1:0]             arrive, chan_hit;
  logic [N_SRC-1:0][W_DATA-1:0] pend_data_reg;

  logic [N_SRC-1:0]  grant;
  logic [W_SRC-1:0]  grant_idx;
  logic              grant_vld;
  logic [W_DATA-1:0] grant_data;

  logic              dv_reg;
  logic [W_SRC-1:0]  src_reg;
  logic [W_DATA-1:0] data_reg;

  wr_op_e wr_op;
  logic   unused_wr_data;

  assign wr_op          = decode_wr(wr_en, int'(wr_addr));
  assign unused_wr_data = ^wr_data[W_WR_DATA-1:1];

  src_arbiter #(
    .N_SRC (N_SRC),
    .W_SRC (W_SRC)
  ) u_arb (
`ifdef SRC_RR_ARB_EN
    .clk       (clk_in),
    .srst      (rst_in),
`endif
    .pend      (pend_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign arrive[gi]      = adc_dv_in[gi] & src_en_reg[gi];
      assign chan_hit[gi]    = (wr_chan == W_WR_CHAN'(gi));
      assign src_en_next[gi] = (wr_op == WR_SRC_EN && chan_hit[gi]) ? wr_data[0] : src_en_reg[gi];
      // Disabling a source discards whatever it had pending; a fresh arrival re-arms even if granted.
      assign pend_next[gi]   = (wr_op == WR_SRC_EN && chan_hit[gi] && !wr_data[0]) ? 1'b0 :
                               arrive[gi] ? 1'b1 :
                               grant[gi]  ? 1'b0 : pend_reg[gi];
      // Overrun set takes precedence over a same-edge clear.
      assign ovr_next[gi]    = (arrive[gi] & pend_reg[gi] & ~grant[gi]) |
                               (ovr_reg[gi] & ~(wr_op == WR_OVR_CLR && chan_hit[gi]));
    end
  endgenerate

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant[k]) grant_data = grant_data | pend_data_reg[k];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_en_reg <= '0;
      pend_reg   <= '0;
      ovr_reg    <= '0;
      dv_reg     <= 1'b0;
      src_reg    <= NULL_SRC;
      data_reg   <= '0;
    end else begin
      src_en_reg <= src_en_next;
      pend_reg   <= pend_next;
      ovr_reg    <= ovr_next;
      dv_reg     <= grant_vld;
      if (grant_vld) begin
        src_reg  <= grant_idx;
        data_reg <= grant_data;
      end
    end
  end

  // Sample storage needs no reset: it is only read while its pend bit is set.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < N_SRC; k++) begin
      if (arrive[k]) pend_data_reg[k] <= adc_data_in[k*W_DATA +: W_DATA];
    end
  end

  assign dv_out   = dv_reg;
  assign src_out  = src_reg;
  assign data_out = data_reg;
  assign ovr_out  = ovr_reg;

endmodule

// File: tb/tb_adc_src_mux.sv
// Self-checking bench for adc_src_mux: directed scenarios plus randomized traffic against a queue-free
// behavioural model; honours SRC_RR_ARB_EN to pick the arbitration rule.
module tb_adc_src_mux;
  import adc_src_mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 18;
  localparam int WS = 5;
  localparam logic [WS-1:0] NULLS = 5'h1F;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [N-1:0]      adc_dv_in;
  logic [N*W-1:0]    adc_data_in;
  logic              wr_en;
  logic [15:0]       wr_addr;
  logic [15:0]       wr_chan;
  logic [47:0]       wr_data;
  logic              dv_out;
  logic [WS-1:0]     src_out;
  logic [W-1:0]      data_out;
  logic [N-1:0]      ovr_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit            m_en   [N];
  bit            m_pend [N];
  bit            m_ovr  [N];
  logic [W-1:0]  m_data [N];
  int            m_last;
  logic          exp_dv;
  logic [WS-1:0] exp_src;
  logic [W-1:0]  exp_data;
  logic [N-1:0]  exp_ovr;

  adc_src_mux dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .adc_dv_in   (adc_dv_in),
    .adc_data_in (adc_data_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .dv_out      (dv_out),
    .src_out     (src_out),
    .data_out    (data_out),
    .ovr_out     (ovr_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [N*W-1:0] put(input logic [N*W-1:0] v, input int k, input logic [W-1:0] d);
    logic [N*W-1:0] r;
    r = v;
    r[k*W +: W] = d;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_en[k] = 0; m_pend[k] = 0; m_ovr[k] = 0; m_data[k] = '0;
    end
    m_last   = N - 1;
    exp_dv   = 1'b0;
    exp_src  = NULLS;
    exp_data = '0;
    exp_ovr  = '0;
  endtask

  // Drive one cycle of stimulus, advance the model by the spec's rules, then step past the edge.
  task automatic tick(input logic [N-1:0] dv, input logic [N*W-1:0] data, input logic we,
                      input int addr, input int chan, input logic [47:0] wd);
    int  g;
    bit  arrive, en_hit, clr_hit;
    adc_dv_in   = dv;
    adc_data_in = data;
    wr_en       = we;
    wr_addr     = 16'(addr);
    wr_chan     = 16'(chan);
    wr_data     = wd;
    g = -1;
`ifdef SRC_RR_ARB_EN
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (m_last + i) % N;
      if (g < 0 && m_pend[c]) g = c;
    end
`else
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) g = i;
`endif
    if (g >= 0) begin
      exp_dv = 1'b1; exp_src = WS'(g); exp_data = m_data[g]; m_last = g;
    end else begin
      exp_dv = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      arrive  = dv[k] && m_en[k];
      en_hit  = we && addr == SRC_EN_ADDR && chan == k;
      clr_hit = we && addr == OVR_CLR_ADDR && chan == k;
      if (arrive && m_pend[k] && g != k) m_ovr[k] = 1;
      else if (clr_hit)                  m_ovr[k] = 0;
      if (g == k) m_pend[k] = 0;
      if (arrive) begin m_pend[k] = 1; m_data[k] = data[k*W +: W]; end
      if (en_hit && !wd[0]) m_pend[k] = 0;
      if (en_hit) m_en[k] = wd[0];
      exp_ovr[k] = m_ovr[k];
    end
    @(posedge clk_in); #1;
    adc_dv_in = '0;
    wr_en     = 1'b0;
  endtask

  task automatic idle();
    tick('0, '0, 1'b0, 0, 0, 48'd0);
  endtask

  task automatic wr(input int addr, input int chan, input logic [47:0] wd);
    tick('0, '0, 1'b1, addr, chan, wd);
  endtask

  // Reset with a capture and an enable write on the same edge; reset must override both.
  task automatic do_reset();
    rst_in      = 1'b1;
    adc_dv_in   = '1;
    adc_data_in = '1;
    wr_en       = 1'b1;
    wr_addr     = 16'(SRC_EN_ADDR);
    wr_chan     = 16'd1;
    wr_data     = 48'd1;
    @(posedge clk_in); #1;
    rst_in    = 1'b0;
    adc_dv_in = '0;
    wr_en     = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0b want 0", dv_out); end
    checks++; if (src_out !== NULLS) begin errors++; $display("FAIL reset_src: got %0d want %0d", src_out, NULLS); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", data_out); end
    checks++; if (ovr_out !== '0) begin errors++; $display("FAIL reset_ovr: got %0h want 0", ovr_out); end
    idle();
    checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL reset_no_capture: got dv %0b want 0", dv_out); end
  endtask

  task automatic test_single();
    int pulses;
    do_reset();
    wr(SRC_EN_ADDR, 2, 48'd1);
    tick(8'b0000_0100, put('0, 2, 18'h1ABCD), 1'b0, 0, 0, 48'd0);
    checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL single_latency: got dv %0b want 0 one edge after pulse", dv_out); end
    idle();
    checks++;
    if (dv_out !== 1'b1 || src_out !== 5'd2 || data_out !== 18'h1ABCD) begin
      errors++; $display("FAIL single_word: got dv %0b src %0d data %0h want 1 2 1abcd", dv_out, src_out, data_out);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin idle(); if (dv_out) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL single_extra: got %0d extra words want 0", pulses); end
    checks++; if (src_out !== 5'd2 || data_out !== 18'h1ABCD) begin
      errors++; $display("FAIL single_hold: got src %0d data %0h want 2 1abcd", src_out, data_out);
    end
  endtask

  task automatic test_all_eight();
    logic [N*W-1:0] d;
    do_reset();
    for (int k = 0; k < N; k++) wr(SRC_EN_ADDR, k, 48'd1);
    d = '0;
    for (int k = 0; k < N; k++) d = put(d, k, 18'(32'h100 + k));
    tick('1, d, 1'b0, 0, 0, 48'd0);
    for (int k = 0; k < N; k++) begin
      idle();
      checks++;
      if (dv_out !== 1'b1 || src_out !== WS'(k) || data_out !== 18'(32'h100 + k)) begin
        errors++; $display("FAIL all8_word%0d: got dv %0b src %0d data %0h want 1 %0d %0h",
                           k, dv_out, src_out, data_out, k, 32'h100 + k);
      end
    end
    idle();
    checks++; if (dv_out !== 1'b0) begin errors++; $display("FAIL all8_end: got dv %0b want 0", dv_out); end
    checks++; if (ovr_out !== '0) begin errors++; $display("FAIL all8_ovr: got %0h want 0", ovr_out); end
  endtask

  task automatic test_contention();
    logic [WS-1:0] want;
    do_reset();
    wr(SRC_EN_ADDR, 1, 48'd1);
    wr(SRC_EN_ADDR, 5, 48'd1);
    for (int i = 0; i < 12; i++) begin
      tick(8'b0010_0010, put(put('0, 1, 18'($urandom)), 5, 18'($urandom)), 1'b0, 0, 0, 48'd0);
      if (i >= 1) begin
`ifdef SRC_RR_ARB_EN
        want = (i % 2 == 1) ? 5'd1 : 5'd5;
`else
        want = 5'd1;
`endif
        checks++;
        if (dv_out !== 1'b1 || src_out !== want) begin
          errors++; $display("FAIL contention_c%0d: got dv %0b src %0d want 1 %0d", i, dv_out, src_out, want);
        end
      end
    end
    checks++; if (ovr_out[5] !== 1'b1) begin errors++; $display("FAIL contention_ovr5: got %0b want 1", ovr_out[5]); end
`ifndef SRC_RR_ARB_EN
    checks++; if (ovr_out[1] !== 1'b0) begin errors++; $display("FAIL contention_ovr1: got %0b want 0", ovr_out[1]); end
`endif
  endtask

  task automatic test_disabled_overrun();
    int n3;
    logic [W-1:0] d3;
    do_reset();
    wr(SRC_EN_ADDR, 0, 48'd1);
    tick(8'b0000_1000, put('0, 3, 18'h3FFFF), 1'b0, 0, 0, 48'd0);
    n3 = 0;
    for (int i = 0; i < 3; i++) begin idle(); if (dv_out) n3++; end
    checks++; if (n3 != 0) begin errors++; $display("FAIL disabled_words: got %0d want 0", n3); end
    checks++; if (ovr_out[3] !== 1'b0) begin errors++; $display("FAIL disabled_ovr: got %0b want 0", ovr_out[3]); end
    wr(SRC_EN_ADDR, 3, 48'd1);
    tick(8'b0000_1001, put(put('0, 0, 18'h00111), 3, 18'h0AAAA), 1'b0, 0, 0, 48'd0);
    n3 = 0; d3 = '0;
    tick(8'b0000_1001, put(put('0, 0, 18'h00222), 3, 18'h0BBBB), 1'b0, 0, 0, 48'd0);
    if (dv_out && src_out == 5'd3) begin n3++; d3 = data_out; end
    for (int i = 0; i < 5; i++) begin
      idle();
      if (dv_out && src_out == 5'd3) begin n3++; d3 = data_out; end
    end
    checks++; if (n3 != 1) begin errors++; $display("FAIL ovr_count3: got %0d words want 1", n3); end
    checks++; if (d3 !== 18'h0BBBB) begin errors++; $display("FAIL ovr_data3: got %0h want bbbb", d3); end
    checks++; if (ovr_out[3] !== 1'b1) begin errors++; $display("FAIL ovr_flag3: got %0b want 1", ovr_out[3]); end
    wr(OVR_CLR_ADDR, 11, 48'd0);
    checks++; if (ovr_out[3] !== 1'b1) begin errors++; $display("FAIL ovr_clr_oob: got %0b want 1", ovr_out[3]); end
    wr(OVR_CLR_ADDR, 3, 48'd0);
    checks++; if (ovr_out[3] !== 1'b0) begin errors++; $display("FAIL ovr_clr3: got %0b want 0", ovr_out[3]); end
  endtask

  task automatic test_reset_pending();
    int pulses;
    do_reset();
    wr(SRC_EN_ADDR, 2, 48'd1);
    wr(SRC_EN_ADDR, 4, 48'd1);
    wr(SRC_EN_ADDR, 6, 48'd1);
    tick(8'b0101_0100, put(put(put('0, 2, 18'h2), 4, 18'h4), 6, 18'h6), 1'b0, 0, 0, 48'd0);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin idle(); if (dv_out) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstpend_words: got %0d want 0", pulses); end
    checks++; if (src_out !== NULLS || data_out !== '0 || ovr_out !== '0) begin
      errors++; $display("FAIL rstpend_outputs: got src %0d data %0h ovr %0h want %0d 0 0", src_out, data_out, ovr_out, NULLS);
    end
    tick(8'b1101_0110, '1, 1'b0, 0, 0, 48'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin idle(); if (dv_out) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstpend_en_cleared: got %0d words want 0", pulses); end
  endtask

  task automatic test_random();
    logic [N-1:0]   dv;
    logic [N*W-1:0] d;
    logic           we;
    int             addr, chan, sel;
    logic [47:0]    wd;
    do_reset();
    for (int k = 0; k < N; k++) wr(SRC_EN_ADDR, k, 48'd1);
    for (int t = 0; t < 400; t++) begin
      dv = N'($urandom) & N'($urandom);
      if (t % 50 > 44) dv = '0;
      d = '0;
      for (int k = 0; k < N; k++) d = put(d, k, 18'($urandom));
      we   = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 2);
      addr = (sel == 0) ? SRC_EN_ADDR : (sel == 1) ? OVR_CLR_ADDR : 'h55;
      chan = $urandom_range(0, 9);
      wd   = {16'($urandom), 32'($urandom)};
      if (addr == SRC_EN_ADDR && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if (we && addr == SRC_EN_ADDR && chan < N && !wd[0]) dv[chan] = 1'b0;
      tick(dv, d, we, addr, chan, wd);
      checks++; if (dv_out !== exp_dv) begin errors++; $display("FAIL rand_dv t%0d: got %0b want %0b", t, dv_out, exp_dv); end
      checks++; if (src_out !== exp_src) begin errors++; $display("FAIL rand_src t%0d: got %0d want %0d", t, src_out, exp_src); end
      checks++; if (data_out !== exp_data) begin errors++; $display("FAIL rand_data t%0d: got %0h want %0h", t, data_out, exp_data); end
      checks++; if (ovr_out !== exp_ovr) begin errors++; $display("FAIL rand_ovr t%0d: got %0h want %0h", t, ovr_out, exp_ovr); end
    end
  endtask

  initial begin
    rst_in      = 1'b1;
    adc_dv_in   = '0;
    adc_data_in = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_chan     = '0;
    wr_data     = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    test_reset();
    test_single();
    test_all_eight();
    test_contention();
    test_disabled_overrun();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
